// File: rtl/prog_loader_pkg.sv
// Shared sizing and state encoding for the instruction-memory program loader.
package prog_loader_pkg;

  localparam int unsigned PlDataWidth = 16;
  localparam int unsigned PlDepth     = 15;
  localparam int unsigned PlAddrWidth = 4;
  localparam int unsigned PlLenMax    = PlDepth;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StHi,
    StLo,
    StWrite,
    StDone,
    StErr
  } pl_state_e;

  // A length byte is usable only if it names at least one word and fits the memory.
  function automatic logic len_ok(input logic [7:0] n, input int unsigned max_len);
    return (n != 8'd0) && (32'(n) <= max_len);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles 16-bit words and writes them to instruction memory,
// holding the CPU until a length-checked image has been fully written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DataWidth = PlDataWidth,
  parameter int unsigned Depth     = PlLenMax,
  parameter int unsigned AddrWidth = PlAddrWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic                 cpu_hold_o,
  output logic                 done_o,
  output logic                 err_o
);

  pl_state_e            state_q, state_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           hi_q, hi_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 hold_q, hold_d;
  logic                 xfer;
  logic                 last_word;

  // Handshake outputs decode the state register only, never byte_valid_i.
  assign byte_ready_o = (state_q == StLen) || (state_q == StHi) || (state_q == StLo);
  assign mem_we_o     = (state_q == StWrite);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign cpu_hold_o   = hold_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

  assign xfer      = byte_valid_i && byte_ready_o;
  assign last_word = (32'(addr_q) == (32'(len_q) - 32'd1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLen;
          addr_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      StLen: begin
        if (xfer) begin
          if (len_ok(byte_i, Depth)) begin
            len_d   = byte_i;
            state_d = StHi;
          end else begin
            state_d = StErr;
          end
        end
      end
      StHi: begin
        if (xfer) begin
          hi_d    = byte_i;
          state_d = StLo;
        end
      end
      StLo: begin
        if (xfer) begin
          wdata_d = DataWidth'({hi_q, byte_i});
          state_d = StWrite;
        end
      end
      StWrite: begin
        // Address advances only after the strobe so addr/data stay stable while mem_we_o=1.
        if (last_word) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + AddrWidth'(1);
          state_d = StHi;
        end
      end
      StDone, StErr: begin
        if (start_i) begin
          state_d = StLen;
          addr_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end else if (state_q == StDone) begin
          done_d = 1'b1;
          hold_d = 1'b0;
        end else begin
          err_d  = 1'b1;
          hold_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven loads, latency and reset corner cases.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [3:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  prog_loader dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .byte_i      (byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .cpu_hold_o  (cpu_hold_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] n;
    bit         exp_err;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          max_gap  = 0;
  wr_t         got[$];
  logic [15:0] words[15];
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-port monitor: records every strobe and checks the address bound.
  always @(negedge clk_i) begin
    if (rst_n === 1'b1 && mem_we_o === 1'b1) begin
      got.push_back(wr_t'{mem_addr_o, mem_wdata_o});
      chk("addr_below_depth", {31'd0, mem_addr_o <= 4'd14}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) tick();
    byte_i       = b;
    byte_valid_i = 1'b1;
    for (int k = 0; k < 50 && !byte_ready_o; k++) tick();
    if (!byte_ready_o) begin
      chk("ready_timeout", 32'd0, 32'd1);
      byte_valid_i = 1'b0;
      return;
    end
    tick();
    byte_valid_i = 1'b0;
    byte_i       = 8'($urandom);
  endtask

  task automatic wait_end();
    for (int k = 0; k < 100; k++) begin
      if (done_o || err_o) return;
      tick();
    end
    chk("end_timeout", 32'd0, 32'd1);
  endtask

  // Reference: N valid words land at addresses 0..N-1 in stream order; bad N writes nothing.
  task automatic check_writes(input string tag, input logic [7:0] n, input bit e);
    int exp_n;
    exp_n = e ? 0 : int'(n);
    chk({tag, "_nwrites"}, got.size(), exp_n);
    for (int i = 0; i < exp_n && i < got.size(); i++) begin
      chk({tag, "_addr"}, {28'd0, got[i].a}, i);
      chk({tag, "_data"}, {16'd0, got[i].d}, {16'd0, words[i]});
    end
  endtask

  task automatic run_load(input string tag, input logic [7:0] n, input bit exp_err);
    got.delete();
    pulse_start();
    send_byte(n);
    if (!exp_err) begin
      for (int i = 0; i < int'(n); i++) begin
        send_byte(words[i][15:8]);
        send_byte(words[i][7:0]);
      end
    end
    wait_end();
    repeat (2) tick();
    chk({tag, "_done"}, {31'd0, done_o}, {31'd0, !exp_err});
    chk({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
    chk({tag, "_hold"}, {31'd0, cpu_hold_o}, {31'd0, exp_err});
    if (exp_err) chk({tag, "_ready_in_err"}, {31'd0, byte_ready_o}, 32'd0);
    check_writes(tag, n, exp_err);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
    chk({tag, "_we"}, {31'd0, mem_we_o}, 32'd0);
    chk({tag, "_addr"}, {28'd0, mem_addr_o}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, mem_wdata_o}, 32'd0);
    chk({tag, "_hold"}, {31'd0, cpu_hold_o}, 32'd1);
    chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 15; i++) words[i] = 16'($urandom);
  endtask

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    #12;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Two-word image with exact write/done latency.
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("t1_we0", {31'd0, mem_we_o}, 32'd1);
    chk("t1_addr0", {28'd0, mem_addr_o}, 32'd0);
    chk("t1_data0", {16'd0, mem_wdata_o}, 32'h1234);
    send_byte(8'hAB);
    send_byte(8'hCD);
    chk("t1_we1", {31'd0, mem_we_o}, 32'd1);
    chk("t1_addr1", {28'd0, mem_addr_o}, 32'd1);
    chk("t1_data1", {16'd0, mem_wdata_o}, 32'hABCD);
    tick();
    chk("t1_done_early", {31'd0, done_o}, 32'd0);
    chk("t1_hold_early", {31'd0, cpu_hold_o}, 32'd1);
    tick();
    chk("t1_done", {31'd0, done_o}, 32'd1);
    chk("t1_hold", {31'd0, cpu_hold_o}, 32'd0);

    // Length table, random payloads.
    vecs[0] = '{8'd1, 1'b0};
    vecs[1] = '{8'd0, 1'b1};
    vecs[2] = '{8'd15, 1'b0};
    vecs[3] = '{8'd16, 1'b1};
    vecs[4] = '{8'hFF, 1'b1};
    vecs[5] = '{8'd3, 1'b0};
    for (int v = 0; v < 6; v++) begin
      rand_words();
      run_load($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp_err);
    end

    // Same two-word image with random valid gaps.
    max_gap  = 5;
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    run_load("gaps", 8'd2, 1'b0);
    rand_words();
    run_load("gaps_full", 8'd15, 1'b0);
    max_gap = 0;

    // Asynchronous reset mid-load, then a clean reload.
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    rst_n    = 1'b1;
    tick();
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    run_load("after_rst", 8'd2, 1'b0);

    // start pulses while receiving are ignored.
    rand_words();
    got.delete();
    pulse_start();
    send_byte(8'd2);
    pulse_start();
    send_byte(words[0][15:8]);
    pulse_start();
    send_byte(words[0][7:0]);
    send_byte(words[1][15:8]);
    pulse_start();
    send_byte(words[1][7:0]);
    wait_end();
    chk("ign_done", {31'd0, done_o}, 32'd1);
    check_writes("ign", 8'd2, 1'b0);

    // Restart from DONE clears status and reloads from address 0.
    got.delete();
    pulse_start();
    chk("restart_done", {31'd0, done_o}, 32'd0);
    chk("restart_hold", {31'd0, cpu_hold_o}, 32'd1);
    chk("restart_addr", {28'd0, mem_addr_o}, 32'd0);
    words[0] = 16'h5AA5;
    send_byte(8'd1);
    send_byte(8'h5A);
    send_byte(8'hA5);
    wait_end();
    chk("restart_fin", {31'd0, done_o}, 32'd1);
    check_writes("restart", 8'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
